// File: rtl/ncc_corr_array_if.sv
// ncc_corr_array_if: descriptor, window and result buses of the NCC correlation array.
//   desc_*   : LANES-wide descriptor beats (valid/ready), lane i at [i*PIX_W +: PIX_W]
//   win_*    : one ROWS-tall window column per transfer (valid/ready), row r at [r*PIX_W +: PIX_W]
//   result_* : signed score plus running index (valid/ready)
// Modports: master drives descriptor/window data and result_ready; slave is the array.
interface ncc_corr_array_if #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
);
  logic                     desc_valid;
  logic                     desc_ready;
  logic [LANES*PIX_W-1:0]   desc_data;
  logic                     win_valid;
  logic                     win_ready;
  logic [ROWS*PIX_W-1:0]    win_data;
  logic                     result_valid;
  logic                     result_ready;
  logic [ACC_W-1:0]         result_data;
  logic [15:0]              result_index;

  modport master (
    output desc_valid, desc_data, win_valid, win_data, result_ready,
    input  desc_ready, win_ready, result_valid, result_data, result_index
  );

  modport slave (
    input  desc_valid, desc_data, win_valid, win_data, result_ready,
    output desc_ready, win_ready, result_valid, result_data, result_index
  );
endinterface

// File: rtl/ncc_corr_array.sv
// ncc_corr_array: ROWS x COLS grid of log-domain (Mitchell) multipliers correlating a stored
// descriptor D against a window W that is shifted in one column at a time. Every column that
// completes a full window yields one signed score through a 3-stage pipeline
// (products -> row sums -> total).
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears everything including D
//   clear : synchronous flush back to LOAD (D retained), beats every handshake
//   bus   : ncc_corr_array_if.slave (descriptor in, window columns in, scores out)
// Build option: define NCC_EXACT_MULT_EN to replace the Mitchell approximation with an exact
// signed multiply in every PE (latency unchanged).
module ncc_corr_array #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
) (
  input logic               clk,
  input logic               rst,
  input logic               clear,
  ncc_corr_array_if.slave   bus
);

  localparam int unsigned NBEATS = ROWS * COLS / LANES;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned FILL_W = $clog2(COLS + 1);
  localparam int unsigned BPR    = COLS / LANES;  // descriptor beats per row
  localparam int unsigned MAG2_W = 2 * PIX_W;
  localparam int unsigned PROD_W = 2 * PIX_W + 1;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q;
  logic [FILL_W-1:0]       fill_q;
  logic signed [PIX_W-1:0] d_q [ROWS][COLS];
  logic signed [PIX_W-1:0] w_q [ROWS][COLS];

  logic                    tok_q, v1_q, v2_q, res_valid_q;
  logic signed [PROD_W-1:0] prod [ROWS][COLS];
  logic signed [PROD_W-1:0] p1_q [ROWS][COLS];
  logic signed [ACC_W-1:0] row_sum [ROWS];
  logic signed [ACC_W-1:0] r2_q [ROWS];
  logic signed [ACC_W-1:0] total;
  logic [ACC_W-1:0]        res_data_q;
  logic [15:0]             res_index_q;

  logic en, desc_fire, win_fire, res_fire, last_beat, completes;

  // Whole pipeline moves only when the output register is free or being drained.
  assign en        = !res_valid_q || bus.result_ready;
  assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));
  assign completes = (fill_q >= FILL_W'(COLS - 1));
  assign desc_fire = bus.desc_valid && bus.desc_ready && !clear;
  assign win_fire  = bus.win_valid && bus.win_ready && !clear;
  assign res_fire  = res_valid_q && bus.result_ready && !clear;

  assign bus.desc_ready   = (state_q == StLoad);
  assign bus.win_ready    = (state_q == StRun) && en;
  assign bus.result_valid = res_valid_q;
  assign bus.result_data  = res_data_q;
  assign bus.result_index = res_index_q;

`ifdef NCC_EXACT_MULT_EN
  function automatic logic signed [PROD_W-1:0] pe_mul(input logic signed [PIX_W-1:0] d,
                                                      input logic signed [PIX_W-1:0] w);
    pe_mul = PROD_W'(d) * PROD_W'(w);
  endfunction
`else
  localparam int unsigned SH_W = 3 * PIX_W + 2;

  // Mitchell product of two magnitudes; fractions carried with PIX_W fractional bits.
  function automatic logic [MAG2_W-1:0] mitchell(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    int unsigned      ka, kb;
    logic [SH_W-1:0]  fa, fb, s, acc;
    ka = 0;
    kb = 0;
    for (int i = 0; i < int'(PIX_W); i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = (SH_W'(a) - (SH_W'(1) << ka)) << (PIX_W - ka);
    fb = (SH_W'(b) - (SH_W'(1) << kb)) << (PIX_W - kb);
    s  = fa + fb;
    if (s < (SH_W'(1) << PIX_W)) acc = ((SH_W'(1) << PIX_W) + s) << (ka + kb);
    else                         acc = s << (ka + kb + 1);
    mitchell = MAG2_W'(acc >> PIX_W);
    if (a == '0 || b == '0) mitchell = '0;
  endfunction

  function automatic logic signed [PROD_W-1:0] pe_mul(input logic signed [PIX_W-1:0] d,
                                                      input logic signed [PIX_W-1:0] w);
    logic [PIX_W-1:0]  ma, mb;
    logic [MAG2_W-1:0] m;
    logic              neg;
    // PIX_W unsigned bits hold |-2^(PIX_W-1)| exactly.
    ma  = d[PIX_W-1] ? -d : d;
    mb  = w[PIX_W-1] ? -w : w;
    neg = d[PIX_W-1] ^ w[PIX_W-1];
    m   = mitchell(ma, mb);
    pe_mul = neg ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StLoad;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StLoad: if (desc_fire && last_beat) state_d = StRun;
        StRun:  state_d = StRun;
      endcase
    end
  end

  // Beat counter, fill counter and window shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      fill_q <= '0;
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) w_q[r][c] <= '0;
    end else if (clear) begin
      beat_q <= '0;
      fill_q <= '0;
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) w_q[r][c] <= '0;
    end else begin
      if (desc_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if (win_fire) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          for (int c = int'(COLS) - 1; c > 0; c--) w_q[r][c] <= w_q[r][c-1];
          w_q[r][0] <= bus.win_data[r*PIX_W +: PIX_W];
        end
        if (fill_q != FILL_W'(COLS)) fill_q <= fill_q + 1'b1;
      end
    end
  end

  // Descriptor store: all lanes of a beat land in one row since COLS is a multiple of LANES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) d_q[r][c] <= '0;
    end else if (desc_fire) begin
      for (int r = 0; r < int'(ROWS); r++)
        for (int b = 0; b < int'(BPR); b++)
          if (beat_q == BEAT_W'(r * int'(BPR) + b))
            for (int i = 0; i < int'(LANES); i++)
              d_q[r][b*LANES+i] <= bus.desc_data[i*PIX_W +: PIX_W];
    end
  end

  // PE products, row sums and total (sums wrap modulo 2^ACC_W)
  always_comb begin
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) prod[r][c] = pe_mul(d_q[r][c], w_q[r][c]);
  end

  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < int'(COLS); c++) row_sum[r] = row_sum[r] + ACC_W'(p1_q[r][c]);
    end
  end

  always_comb begin
    total = '0;
    for (int r = 0; r < int'(ROWS); r++) total = total + r2_q[r];
  end

  // Pipeline: token stage (with W), S1 products, S2 row sums, S3 result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        r2_q[r] <= '0;
        for (int c = 0; c < int'(COLS); c++) p1_q[r][c] <= '0;
      end
    end else if (clear) begin
      tok_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      if (en) begin
        tok_q       <= win_fire && completes;
        v1_q        <= tok_q;
        p1_q        <= prod;
        v2_q        <= v1_q;
        r2_q        <= row_sum;
        res_valid_q <= v2_q;
        if (v2_q) res_data_q <= total;
      end
      if (desc_fire && last_beat) res_index_q <= '0;
      else if (res_fire)          res_index_q <= res_index_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ncc_corr_array.sv
module tb_ncc_corr_array;
  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int ACC_W  = 24;
  localparam int NBEATS = ROWS * COLS / LANES;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  ncc_corr_array_if #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .LANES(LANES), .ACC_W(ACC_W))
    bus ();

  ncc_corr_array #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total_n = 0;
  int bad_n   = 0;

  // Reference state
  int d_m [ROWS][COLS];
  int w_m [ROWS][COLS];
  int fill_m;
  int idx_m;
  logic [ACC_W-1:0] exp_q[$];
  int               exp_idx_q[$];

  int d_stim [ROWS][COLS];
  int col_stim [ROWS];
  int rr_mode = 0;
  logic [ACC_W-1:0] last_data;
  logic [ACC_W-1:0] mon_e;
  int               mon_i;

  task automatic check(input string name, input longint act, input longint exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Mitchell approximation straight from its definition, using real arithmetic.
  function automatic int mitchell(input int a, input int b);
    int  ka, kb;
    real fa, fb, s, r;
    if (a == 0 || b == 0) return 0;
    ka = 0;
    kb = 0;
    while ((1 << (ka + 1)) <= a) ka++;
    while ((1 << (kb + 1)) <= b) kb++;
    fa = real'(a - (1 << ka)) / real'(1 << ka);
    fb = real'(b - (1 << kb)) / real'(1 << kb);
    s  = fa + fb;
    if (s < 1.0) r = real'(1 << (ka + kb)) * (1.0 + s);
    else         r = real'(1 << (ka + kb + 1)) * s;
    return int'($floor(r));
  endfunction

  function automatic int pe_ref(input int d, input int w);
`ifdef NCC_EXACT_MULT_EN
    return d * w;
`else
    int p;
    p = mitchell(iabs(d), iabs(w));
    return ((d < 0) != (w < 0)) ? -p : p;
`endif
  endfunction

  function automatic logic [ACC_W-1:0] score_ref();
    longint s = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) s += longint'(pe_ref(d_m[r][c], w_m[r][c]));
    return ACC_W'(s);
  endfunction

  task automatic reset_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        d_m[r][c] = 0;
        w_m[r][c] = 0;
      end
    fill_m = 0;
    idx_m  = 0;
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one pop per result handshake
  always @(negedge clk) begin
    if (!rst && !clear && bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        total_n++;
        bad_n++;
        $display("FAIL unexpected_result: got %0d expected no result", bus.result_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_i = exp_idx_q.pop_front();
        check("score", longint'(bus.result_data), longint'(mon_e));
        check("index", longint'(bus.result_index), longint'(mon_i));
      end
      last_data = bus.result_data;
    end
  end

  initial begin
    bus.result_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.result_ready = 1'b1;
        1:       bus.result_ready = ($urandom_range(0, 3) != 0);
        default: bus.result_ready = 1'b0;
      endcase
    end
  end

  task automatic load_desc(input int nb);
    int t, n;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.desc_valid = 1'b0;
        cyc();
      end
      bus.desc_valid = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        n = b * LANES + i;
        bus.desc_data[i*PIX_W +: PIX_W] = PIX_W'(d_stim[n / COLS][n % COLS]);
      end
      t = 0;
      forever begin
        @(negedge clk);
        if (bus.desc_ready) break;
        cyc();
        t++;
        if (t > 100) begin
          $display("FAIL desc_timeout: got no desc_ready expected accept within 100 cycles");
          $fatal(1);
        end
      end
      for (int i = 0; i < LANES; i++) begin
        n = b * LANES + i;
        d_m[n / COLS][n % COLS] = d_stim[n / COLS][n % COLS];
      end
      if (b == NBEATS - 1) idx_m = 0;
      cyc();
    end
    bus.desc_valid = 1'b0;
  endtask

  task automatic send_col(input bit gap);
    int t;
    if (gap && $urandom_range(0, 2) == 0) begin
      bus.win_valid = 1'b0;
      cyc();
    end
    bus.win_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) bus.win_data[r*PIX_W +: PIX_W] = PIX_W'(col_stim[r]);
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.win_ready) break;
      cyc();
      t++;
      if (t > 200) begin
        $display("FAIL win_timeout: got no win_ready expected accept within 200 cycles");
        $fatal(1);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = COLS - 1; c > 0; c--) w_m[r][c] = w_m[r][c-1];
      w_m[r][0] = col_stim[r];
    end
    if (fill_m >= COLS - 1) begin
      exp_q.push_back(score_ref());
      exp_idx_q.push_back(idx_m);
      idx_m++;
    end
    if (fill_m < COLS) fill_m++;
    cyc();
    bus.win_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_m[r][c] = 0;
    fill_m = 0;
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      cyc();
      t++;
    end
    check(name, exp_q.size(), 0);
    cyc();
  endtask

  task automatic fill_d(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) d_stim[r][c] = v;
  endtask

  task automatic fill_col(input int v);
    for (int r = 0; r < ROWS; r++) col_stim[r] = v;
  endtask

  task automatic rand_d();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) d_stim[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic rand_col();
    for (int r = 0; r < ROWS; r++) col_stim[r] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Single-pixel case: D[0][0]=dv, final column carries wv in row 0, everything else 0.
  task automatic directed(input string name, input int dv, input int wv,
                          input logic [ACC_W-1:0] want);
    do_clear();
    fill_d(0);
    d_stim[0][0] = dv;
    load_desc(NBEATS);
    fill_col(0);
    for (int k = 0; k < COLS - 1; k++) send_col(1'b0);
    col_stim[0] = wv;
    send_col(1'b0);
    drain({name, "_drain"});
    check(name, longint'(last_data), longint'(want));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_data  = '0;
    bus.win_valid  = 1'b0;
    bus.win_data   = '0;
    last_data      = '0;
    reset_model();
    repeat (3) cyc();
    check("rst_desc_ready", bus.desc_ready, 1);
    check("rst_win_ready", bus.win_ready, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result_data", bus.result_data, 0);
    check("rst_result_index", bus.result_index, 0);
    rst = 1'b0;
    cyc();

    // All ones: latency, value 256, index after handshake
    fill_d(1);
    load_desc(NBEATS);
    check("load_exit_desc_ready", bus.desc_ready, 0);
    check("load_exit_win_ready", bus.win_ready, 1);
    fill_col(1);
    for (int k = 0; k < COLS; k++) send_col(1'b0);
    repeat (3) @(negedge clk);
    check("latency_early", bus.result_valid, 0);
    @(negedge clk);
    check("latency_valid", bus.result_valid, 1);
    @(negedge clk);
    check("after_hs_valid", bus.result_valid, 0);
    check("after_hs_index", bus.result_index, 1);
    check("ones_value", longint'(last_data), 256);
    cyc();

    // Single-pixel boundary cases
`ifdef NCC_EXACT_MULT_EN
    directed("d3_w3", 3, 3, 24'd9);
`else
    directed("d3_w3", 3, 3, 24'd8);
`endif
    directed("d2_w4", 2, 4, 24'd8);
    directed("dm2_w4", -2, 4, 24'hFFFFF8);
    directed("dm2_w0", -2, 0, 24'd0);

    // Full-scale negative pixels everywhere
    do_clear();
    fill_d(-128);
    load_desc(NBEATS);
    fill_col(-128);
    for (int k = 0; k < COLS; k++) send_col(1'b0);
    drain("m128_drain");
    check("m128_value", longint'(last_data), 24'h400000);

    // Random descriptor and stream with random back-pressure
    do_clear();
    rand_d();
    load_desc(NBEATS);
    rr_mode = 1;
    for (int k = 0; k < 40; k++) begin
      rand_col();
      send_col(1'b1);
    end
    rr_mode = 0;
    drain("random_drain");

    // Stall for 5 cycles with scores in flight
    rr_mode = 2;
    bus.result_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_col();
      send_col(1'b0);
    end
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", bus.result_valid, 1);
      check("stall_win_ready", bus.win_ready, 0);
      check("stall_data", longint'(bus.result_data), longint'(exp_q[0]));
      cyc();
    end
    rr_mode = 0;
    for (int k = 0; k < 2; k++) begin
      rand_col();
      send_col(1'b0);
    end
    drain("stall_drain");

    // clear two cycles after a completing column: its score must never appear
    rand_col();
    send_col(1'b0);
    cyc();
    do_clear();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("clear_no_result", bus.result_valid, 0);
    end
    check("clear_desc_ready", bus.desc_ready, 1);
    cyc();

    // Asynchronous reset in the middle of beat 30, then a full reload
    rand_d();
    load_desc(30);
    bus.desc_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_desc_ready", bus.desc_ready, 1);
    check("rst_mid_win_ready", bus.win_ready, 0);
    check("rst_mid_result_valid", bus.result_valid, 0);
    check("rst_mid_result_index", bus.result_index, 0);
    reset_model();
    bus.desc_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rand_d();
    load_desc(NBEATS);
    check("reload_win_ready", bus.win_ready, 1);
    check("reload_desc_ready", bus.desc_ready, 0);
    for (int k = 0; k < 20; k++) begin
      rand_col();
      send_col(1'b1);
    end
    drain("reload_drain");

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/ncc_corr_array.md
# ncc_corr_array

Parametrised successor of the 16x16 NCC processing-element grid: a ROWS x COLS array of log-domain (Mitchell) multipliers that correlates a stored descriptor against a streamed image window. It takes descriptor pixels over a valid/ready bus in LANES-wide beats and shifts window columns through the array. For every window alignment it emits one signed correlation score through a 3-stage pipelined adder tree. It sits between the descriptor/window DMA front end and the match-selection logic.

## Interface
- ROWS, 16, array rows
- COLS, 16, array columns; COLS % LANES == 0 required
- PIX_W, 8, signed two's-complement pixel width
- LANES, 4, descriptor pixels per desc beat
- ACC_W, 24, signed score width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush; returns block to LOAD
- desc_valid  in  1  descriptor beat valid
- desc_ready  out  1  descriptor beat accepted when both high
- desc_data  in  LANES*PIX_W  lane i at bits [i*PIX_W +: PIX_W]
- win_valid  in  1  window column valid
- win_ready  out  1  window column accepted when both high
- win_data  in  ROWS*PIX_W  row r pixel at bits [r*PIX_W +: PIX_W]
- result_valid  out  1  score valid
- result_ready  in  1  score consumed when both high
- result_data  out  ACC_W  signed correlation score
- result_index  out  16  count of scores emitted since last LOAD exit, wraps at 2^16

## Operation
- States: LOAD, RUN. Reset and clear both enter LOAD.
- LOAD: desc_ready=1, win_ready=0. Beat b, lane i writes linear index n=b*LANES+i into D[n/COLS][n%COLS]. After beat ROWS*COLS/LANES-1 is accepted, the next state is RUN and the beat counter returns to 0.
- RUN: desc_ready=0, win_ready=en, where en = !result_valid || result_ready.
- Window column shift on each accepted column: W[r][c] <= W[r][c-1] for c>0, and W[r][0] <= win_data row r. A fill counter saturates at COLS.
- Accepted column with fill already >= COLS-1 (i.e. it completes the window): a valid token enters the pipeline. Otherwise a bubble enters.
- Per-PE product P = sign(D)^sign(W) applied to approxmul(|D|,|W|). |x| uses PIX_W bits, so |-2^(PIX_W-1)| is exact.
- approxmul(a,b): if either operand is 0, result 0. Otherwise:
  - k = msb index; f = (m-2^k) as an F=PIX_W-bit fraction; s = fa+fb.
  - s < 1: result floor(2^(ka+kb)*(1+s)).
  - s >= 1: result floor(2^(ka+kb+1)*s).
  - A negative sign yields -result; zero is never negated.
- Score = sum over r,c of P[r][c], in two's complement modulo 2^ACC_W (wraps, no saturation).
- clear in any state: state to LOAD; beat counter, fill, W, pipeline valids and result_valid cleared next edge. D is retained but overwritten by the next load. clear has priority over every handshake in the same cycle.
- rst mid-load or mid-run: all registers including D are zeroed immediately.

## Timing
- Reset values:
  - desc_ready=1, win_ready=0, result_valid=0, result_data=0, result_index=0.
  - D=0, W=0, state LOAD.
- Pipeline stages, each advancing only when en=1:
  - S1: PE products registered.
  - S2: per-row sums registered.
  - S3: total registered into result_data/result_valid.
- Latency: a column accepted at edge N gives result_valid at edge N+3 if en stays 1.
- Stall (result_valid=1, result_ready=0):
  - All stages hold; result_data is stable; win_ready=0.
  - desc_ready is unaffected in LOAD.
- result_index increments on each result handshake.
- Full throughput of 1 score/cycle with result_ready held high.
- Last desc beat accepted at edge N: desc_ready=0 and win_ready=1 from cycle N+1.
- Tokens in flight at LOAD entry via clear are discarded. No result appears after clear.

## Configuration
- NCC_EXACT_MULT_EN defined: each PE uses an exact signed PIX_W x PIX_W multiply; pipeline latency is unchanged.
- Undefined (default): Mitchell approxmul as specified above.

## Test plan
- All D=1, all W columns=1, result_ready=1: first result_valid 3 cycles after the 16th column, result_data=256, result_index=1 after handshake.
- D[0][0]=3 (others 0), W[0][0]=3 on the completing column: result 8. With NCC_EXACT_MULT_EN the result is 9. D=2,W=4 gives 8 in both modes.
- D[0][0]=-2, W[0][0]=4: result -8 (0xFFFFF8). D=-2, W=0: result 0.
- All D=-128 and all W=-128: result 16384*256=0x400000 in both modes.
- result_ready=0 for 5 cycles mid-stream: result_data constant, win_ready=0, no score lost or duplicated; scores resume in order.
- clear 2 cycles after a column, then rst asserted mid-LOAD beat 30: no result_valid after clear; after rst, desc_ready=1, D=0, and a reload of 64 beats re-enters RUN.
